max_min_scan_ctrl: RTL and testbench

//  Sequences one shared unsigned max/min comparator over a frame of COUNT samples

---
 rtl/max_min_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_max_min_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_min_scan_ctrl.sv
// max_min_scan_ctrl: steps one shared unsigned max/min comparator across a
// frame of COUNT samples taken from a valid/ready stream. The frame extrema are
// then offered on a valid/ready result port.
// Optional feature macro: MAXMIN_INDEX_EN adds out_max_idx/out_min_idx, which
// give the 0-based frame position of the first occurrence of each extremum.
module max_min_scan_ctrl #(
  parameter int WIDTH = 4,
  parameter int COUNT = 8,
  localparam int CW   = $clog2(COUNT + 1),
  localparam int IDXW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min
`ifdef MAXMIN_INDEX_EN
  ,
  output logic [IDXW-1:0]  out_max_idx,
  output logic [IDXW-1:0]  out_min_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic          accept;
  logic          last_in_scan;

  assign accept       = in_valid & in_ready;
  assign last_in_scan = (count == CW'(COUNT - 1));

  // State register; an asynchronous reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. in_ready depends only on the state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = (COUNT == 1) ? DONE : SCAN;
      end
      SCAN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_in_scan) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Running extrema and sample counter. The first sample seeds both extrema.
  // The strict compares mean ties keep the earlier value. The result registers
  // are updated only on accepts, so they hold steady in DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      out_max <= '0;
      out_min <= '0;
`ifdef MAXMIN_INDEX_EN
      out_max_idx <= '0;
      out_min_idx <= '0;
`endif
    end else if (accept) begin
      if (state == LOAD) begin
        out_max <= in_data;
        out_min <= in_data;
        count   <= CW'(1);
`ifdef MAXMIN_INDEX_EN
        out_max_idx <= '0;
        out_min_idx <= '0;
`endif
      end else begin
        if (in_data > out_max) begin
          out_max <= in_data;
`ifdef MAXMIN_INDEX_EN
          out_max_idx <= IDXW'(count);
`endif
        end
        if (in_data < out_min) begin
          out_min <= in_data;
`ifdef MAXMIN_INDEX_EN
          out_min_idx <= IDXW'(count);
`endif
        end
        count <= count + CW'(1);
      end
    end else if ((state == DONE) && out_ready) begin
      count <= '0;
    end
  end

endmodule

// File: tb/tb_max_min_scan_ctrl.sv
// tb_max_min_scan_ctrl: self-checking bench for max_min_scan_ctrl. It uses
// directed frames and randomized frames with gaps and back-pressure. Expected
// extrema come from a plain software loop over each frame.
// MAXMIN_INDEX_EN, when defined, also enables the index port checks.
module tb_max_min_scan_ctrl;

  localparam int WIDTH = 4;
  localparam int COUNT = 8;
  localparam int IDXW  = 3;

  typedef logic [WIDTH-1:0] frame_t [COUNT];

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
`ifdef MAXMIN_INDEX_EN
  logic [IDXW-1:0]  out_max_idx;
  logic [IDXW-1:0]  out_min_idx;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_max = '0;
  logic [WIDTH-1:0] exp_min = '0;
  int               exp_max_idx = 0;
  int               exp_min_idx = 0;

  max_min_scan_ctrl #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min)
`ifdef MAXMIN_INDEX_EN
    ,
    .out_max_idx (out_max_idx),
    .out_min_idx (out_min_idx)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a linear search for the extrema and their first positions.
  function automatic void model(input frame_t f);
    exp_max     = f[0];
    exp_min     = f[0];
    exp_max_idx = 0;
    exp_min_idx = 0;
    for (int i = 1; i < COUNT; i++) begin
      if (f[i] > exp_max) begin
        exp_max     = f[i];
        exp_max_idx = i;
      end
      if (f[i] < exp_min) begin
        exp_min     = f[i];
        exp_min_idx = i;
      end
    end
  endfunction

  // Runs one frame from IDLE. gap < 0 selects random idle cycles before each
  // sample. stall sets the number of cycles out_ready is held low in DONE.
  task automatic run_frame(input frame_t f, input int gap, input int stall,
                           input bit pulse_start, input bit hold_start);
    int g;
    model(f);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_entry: in_ready=%b busy=%b out_valid=%b expected 1 1 0",
               in_ready, busy, out_valid);
    end
    for (int i = 0; i < COUNT; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL gap_wait: in_ready=%b out_valid=%b expected 1 0",
                   in_ready, out_valid);
        end
      end
      in_valid = 1'b1;
      in_data  = f[i];
      @(posedge clk); #1;
      if (i < COUNT - 1) begin
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL scan_state: sample %0d in_ready=%b out_valid=%b expected 1 0",
                   i, in_ready, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== exp_max || out_min !== exp_min) begin
      errors++;
      $display("[TB] FAIL result: valid=%b ready=%b max=%0d min=%0d expected 1 0 %0d %0d",
               out_valid, in_ready, out_max, out_min, exp_max, exp_min);
    end
`ifdef MAXMIN_INDEX_EN
    checks++;
    if (out_max_idx !== IDXW'(exp_max_idx) || out_min_idx !== IDXW'(exp_min_idx)) begin
      errors++;
      $display("[TB] FAIL result_idx: max_idx=%0d min_idx=%0d expected %0d %0d",
               out_max_idx, out_min_idx, exp_max_idx, exp_min_idx);
    end
`endif
    out_ready = 1'b0;
    repeat (stall) begin
      if (pulse_start) start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== exp_max || out_min !== exp_min) begin
        errors++;
        $display("[TB] FAIL backpressure: valid=%b ready=%b max=%0d min=%0d expected 1 0 %0d %0d",
                 out_valid, in_ready, out_max, out_min, exp_max, exp_min);
      end
    end
    start     = hold_start;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_max !== exp_max || out_min !== exp_min) begin
      errors++;
      $display("[TB] FAIL result_taken: valid=%b busy=%b max=%0d min=%0d expected 0 0 %0d %0d",
               out_valid, busy, out_max, out_min, exp_max, exp_min);
    end
  endtask

  // Reset values while rst_n is held low, then release.
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_max !== '0 || out_min !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: ready=%b busy=%b valid=%b max=%0d min=%0d expected all 0",
               in_ready, busy, out_valid, out_max, out_min);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    frame_t f;
    f = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd0, 4'd7, 4'd7, 4'd2};
    run_frame(f, 0, 0, 1'b0, 1'b0);
    f = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    run_frame(f, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    frame_t f;
    f = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd0, 4'd7, 4'd7, 4'd2};
    run_frame(f, 2, 0, 1'b0, 1'b0);
  endtask

  // start pulsed while the result waits must not launch a new frame.
  task automatic test_back_pressure();
    frame_t f;
    f = '{4'd6, 4'd2, 4'd11, 4'd2, 4'd11, 4'd4, 4'd9, 4'd1};
    run_frame(f, 0, 5, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_restart: busy=%b in_ready=%b expected 0 0", busy, in_ready);
    end
  endtask

  // start held high re-arms on the cycle after DONE->IDLE.
  task automatic test_back_to_back();
    frame_t f;
    f = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    run_frame(f, 0, 1, 1'b0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rearm: busy=%b in_ready=%b expected 1 1", busy, in_ready);
    end
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reset mid-frame clears everything without waiting for a clock edge.
  task automatic test_abort();
    frame_t f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(4'd9 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_max !== '0 || out_min !== '0) begin
      errors++;
      $display("[TB] FAIL async_abort: ready=%b busy=%b valid=%b max=%0d min=%0d expected all 0",
               in_ready, busy, out_valid, out_max, out_min);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    f = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd1};
    run_frame(f, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    frame_t f;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < COUNT; i++) f[i] = WIDTH'($urandom);
      run_frame(f, -1, int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
      start = 1'b0;
    end
  endtask

  // Scenario sequence. Every drive is a bounded number of cycles.
  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_back_pressure();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
